// File: rtl/hack_alu_pkg.sv
// Shared types and constants for the pipelined Hack ALU.
// Control-word layout, FSM states and the common Hack control codes.
package hack_alu_pkg;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam alu_ctrl_t C_ZERO      = 6'b101010;
    localparam alu_ctrl_t C_ONE       = 6'b111111;
    localparam alu_ctrl_t C_X         = 6'b001100;
    localparam alu_ctrl_t C_Y         = 6'b110000;
    localparam alu_ctrl_t C_X_PLUS_Y  = 6'b000010;
    localparam alu_ctrl_t C_X_MINUS_Y = 6'b010011;
    localparam alu_ctrl_t C_X_AND_Y   = 6'b000000;

endpackage

// File: rtl/hack_alu_comb.sv
// Combinational Hack ALU datapath: operand preprocessing plus the f/no stage.
// Carry and signed-overflow outputs exist only when ALU_OVF_EN is defined.
module hack_alu_comb
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  alu_ctrl_t        ctrl,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
`ifdef ALU_OVF_EN
    output logic             cy,
    output logic             ov,
`endif
    output logic [WIDTH-1:0] o
);

    logic [WIDTH-1:0] r;
`ifdef ALU_OVF_EN
    logic [WIDTH:0] sum;
`else
    logic [WIDTH-1:0] sum;
`endif

    always_comb begin
        a = ctrl.zx ? '0 : x;
        if (ctrl.nx) a = ~a;
        b = ctrl.zy ? '0 : y;
        if (ctrl.ny) b = ~b;
`ifdef ALU_OVF_EN
        sum = {1'b0, a} + {1'b0, b};
        // Flags describe the raw sum, before the optional output inversion.
        cy  = ctrl.f & sum[WIDTH];
        ov  = ctrl.f & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
`else
        sum = a + b;
`endif
        r = ctrl.f ? sum[WIDTH-1:0] : (a & b);
        o = ctrl.no ? ~r : r;
    end

endmodule

// File: rtl/hack_alu_pipe.sv
// Registered, handshaked Hack ALU with an iterative shift-add multiply mode.
// Define ALU_OVF_EN to add registered carry (cy) and overflow (ov) outputs.
module hack_alu_pipe
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zr,
    output logic             ng,
`ifdef ALU_OVF_EN
    output logic             cy,
    output logic             ov,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    alu_ctrl_t        ctrl_in;
    logic [WIDTH-1:0] pre_a, pre_b, alu_o;
    logic [WIDTH-1:0] acc, acc_nxt, mcand, mplier, o_q;
    logic [CW-1:0]    cnt;
    logic             no_q, accept, last;
`ifdef ALU_OVF_EN
    logic             alu_cy, alu_ov, cy_q, ov_q;
`endif

    assign ctrl_in = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

    hack_alu_comb #(.WIDTH(WIDTH)) u_comb (
        .x    (x),
        .y    (y),
        .ctrl (ctrl_in),
        .a    (pre_a),
        .b    (pre_b),
`ifdef ALU_OVF_EN
        .cy   (alu_cy),
        .ov   (alu_ov),
`endif
        .o    (alu_o)
    );

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready. A result that has not
    // transferred stays stable, and the requester holds in_valid until accepted.
    assign in_ready  = (state == IDLE) || ((state == OUT) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign busy      = (state == MUL);
    assign last      = (cnt == CW'(WIDTH - 1));
    assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;

    assign o  = o_q;
    assign zr = (o_q == '0);
    assign ng = o_q[WIDTH-1];
`ifdef ALU_OVF_EN
    assign cy = cy_q;
    assign ov = ov_q;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = mul ? MUL : OUT;
            MUL:  if (last) state_nxt = OUT;
            OUT: begin
                if (accept)         state_nxt = mul ? MUL : OUT;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            o_q    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            no_q   <= 1'b0;
`ifdef ALU_OVF_EN
            cy_q   <= 1'b0;
            ov_q   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (mul) begin
                    mcand  <= pre_a;
                    mplier <= pre_b;
                    acc    <= '0;
                    cnt    <= '0;
                    no_q   <= no;
                end else begin
                    o_q <= alu_o;
`ifdef ALU_OVF_EN
                    cy_q <= alu_cy;
                    ov_q <= alu_ov;
`endif
                end
            end else if (state == MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                // Final step publishes the product directly, saving a cycle.
                if (last) begin
                    o_q <= no_q ? ~acc_nxt : acc_nxt;
`ifdef ALU_OVF_EN
                    cy_q <= 1'b0;
                    ov_q <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed bench for hack_alu_pipe (WIDTH=16); inputs driven and outputs sampled on negedge.
// Builds with or without ALU_OVF_EN.
module tb_hack_alu_pipe;

    localparam int WIDTH = 16;

    logic             clk, rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] x, y;
    logic             zx, nx, zy, ny, f, no, mul;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] o;
    logic             zr, ng, busy;
`ifdef ALU_OVF_EN
    logic             cy, ov;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [WIDTH-1:0] exp_q[$];

    hack_alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .mul       (mul),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .zr        (zr),
        .ng        (ng),
`ifdef ALU_OVF_EN
        .cy        (cy),
        .ov        (ov),
`endif
        .busy      (busy)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic set_in(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                          input logic [5:0] code, input logic m);
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = code;
        mul = m;
        in_valid = 1'b1;
    endtask

    // Present a request and return on the negedge after its accept edge.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                         input logic [5:0] code, input logic m);
        int waited;
        waited = 0;
        set_in(xv, yv, code, m);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] eo,
                           input logic ezr, input logic eng);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_o"},     32'(o),         32'(eo));
        chk({tag, "_zr"},    32'(zr),        32'(ezr));
        chk({tag, "_ng"},    32'(ng),        32'(eng));
    endtask

    // Multiply: count busy cycles and latency from the accept cycle.
    task automatic run_mul(input string tag, input logic [5:0] code, input logic [WIDTH-1:0] eo);
        int lat, busy_cnt;
        do_op(tag, 16'd300, 16'd300, code, 1'b1);
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy && !in_ready) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"},  32'(lat),      32'd17);
        chk({tag, "_busy_cyc"}, 32'(busy_cnt), 32'd16);
        chk({tag, "_busy_end"}, 32'(busy),     32'd0);
        chk_out(tag, eo, 1'b0, eo[WIDTH-1]);
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0; y = '0;
        {zx, nx, zy, ny, f, no} = 6'b0;
        mul = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_o",     32'(o),         32'd0);
        chk("rst_zr",    32'(zr),        32'd1);
        chk("rst_ng",    32'(ng),        32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd1);

        // Single-cycle ALU operations
        do_op("add", 16'd5, 16'd3, 6'b000010, 1'b0);
        chk_out("add", 16'd8, 1'b0, 1'b0);
`ifdef ALU_OVF_EN
        chk("add_cy", 32'(cy), 32'd0);
        chk("add_ov", 32'(ov), 32'd0);
`endif
        @(negedge clk);
        do_op("sub", 16'd3, 16'd5, 6'b010011, 1'b0);
        chk_out("sub", 16'hFFFE, 1'b0, 1'b1);
        @(negedge clk);
        do_op("zero", 16'd3, 16'd5, 6'b101010, 1'b0);
        chk_out("zero", 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        do_op("and", 16'h00F0, 16'h0FF0, 6'b000000, 1'b0);
        chk_out("and", 16'h00F0, 1'b0, 1'b0);
        @(negedge clk);

        // Multiply, plain and inverted
        run_mul("mul", 6'b000000, 16'h5F90);
        run_mul("mul_no", 6'b000001, 16'hA06F);

        // Back-to-back stream, one result per cycle
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd30);
        exp_q.push_back(16'd300);
        exp_q.push_back(16'h1234);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_in(16'd1,     16'd2,     6'b000010, 1'b0);
                1: set_in(16'd10,    16'd20,    6'b000010, 1'b0);
                2: set_in(16'd100,   16'd200,   6'b000010, 1'b0);
                default: set_in(16'h1000, 16'h0234, 6'b000010, 1'b0);
            endcase
            chk("stream_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_o", 32'(o), 32'(exp_q.pop_front()));
        end

        // Consumer stalls with a new request pending
        out_ready = 1'b0;
        set_in(16'd7, 16'd8, 6'b000010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_o",     32'(o),         32'h1234);
            chk("stall_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("after_stall", 16'd15, 1'b0, 1'b0);
        @(negedge clk);

        // Reset in the middle of a multiply
        do_op("mul_rst", 16'd300, 16'd300, 6'b000000, 1'b1);
        k = 1;
        while (k < 5) begin
            @(negedge clk);
            k++;
        end
        chk("mul_rst_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mul_rst_valid", 32'(out_valid), 32'd0);
        chk("mul_rst_o",     32'(o),         32'd0);
        chk("mul_rst_zr",    32'(zr),        32'd1);
        chk("mul_rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready),  32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        do_op("post_rst_add", 16'd1, 16'd1, 6'b000010, 1'b0);
        chk_out("post_rst_add", 16'd2, 1'b0, 1'b0);
        @(negedge clk);

`ifdef ALU_OVF_EN
        do_op("ovf", 16'h7FFF, 16'd1, 6'b000010, 1'b0);
        chk_out("ovf", 16'h8000, 1'b0, 1'b1);
        chk("ovf_ov", 32'(ov), 32'd1);
        chk("ovf_cy", 32'(cy), 32'd0);
        @(negedge clk);
        do_op("carry", 16'hFFFF, 16'd1, 6'b000010, 1'b0);
        chk_out("carry", 16'h0000, 1'b1, 1'b0);
        chk("carry_cy", 32'(cy), 32'd1);
        chk("carry_ov", 32'(ov), 32'd0);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
